// File: rtl/gf_div_if.sv
// gf_div_if
//   Handshake bundle for the GF(2^m) divider.
//   slave  : the divider side (receives n/d, presents q/div_zero).
//   master : the requester side (issues n/d, takes q/div_zero).
//   Signals:
//     in_valid/in_ready   - n/d offer and acceptance
//     n, d                - numerator and denominator (M bits)
//     out_valid/out_ready - result offer and acceptance
//     q, div_zero         - quotient and "denominator was zero" flag
interface gf_div_if #(
  parameter int M = 8
);
  logic         in_valid;
  logic         in_ready;
  logic [M-1:0] n;
  logic [M-1:0] d;
  logic         out_valid;
  logic         out_ready;
  logic [M-1:0] q;
  logic         div_zero;

  modport slave (
    input  in_valid, n, d, out_ready,
    output in_ready, out_valid, q, div_zero
  );

  modport master (
    output in_valid, n, d, out_ready,
    input  in_ready, out_valid, q, div_zero
  );
endinterface

// File: rtl/gf_div.sv
// gf_div
//   Sequential GF(2^M) divider: q = n * d^(2^M - 2), with the inverse formed by
//   square-and-multiply on a single MSB-first bit-serial multiplier.
//   Fixed latency of (2M-1)*M cycles from the accept edge to out_valid.
//   Ports:
//     clk   - clock, all state updates on the rising edge
//     reset - asynchronous, active-high
//     bus   - gf_div_if slave modport (n/d in, q/div_zero out, valid/ready both sides)
//   Parameters:
//     M - field degree / datapath width
//     P - primitive polynomial low coefficients (x^M implied)
module gf_div #(
  parameter int           M = 8,
  parameter logic [M-1:0] P = 'h1D
) (
  input logic     clk,
  input logic     reset,
  gf_div_if.slave bus
);

  localparam int CW = $clog2(M);

  typedef enum logic [2:0] {IDLE, SQR, MUL, FIN, DONE} state_t;

  state_t         state;
  logic [M-1:0]   n_r;
  logic [M-1:0]   sq;
  logic [M-1:0]   acc;
  logic [M-1:0]   mul_a;
  logic [M-1:0]   mul_b;
  logic [M-1:0]   mul_r;
  logic [M-1:0]   q_r;
  logic [CW-1:0]  cnt;
  logic [CW-1:0]  stp;
  logic           dz_r;
  logic           dz_out;
  logic           in_ready_r;
  logic           out_valid_r;

  logic [CW-1:0]  bit_idx;
  logic [M-1:0]   mul_next;
  logic           last;

  // One step of the MSB-first multiply: shift/reduce the partial product and
  // add mul_a when the current multiplier bit is set.
  always_comb begin
    bit_idx  = CW'(M - 1) - cnt;
    mul_next = {mul_r[M-2:0], 1'b0}
             ^ (mul_r[M-1]    ? P     : '0)
             ^ (mul_b[bit_idx] ? mul_a : '0);
    last     = (cnt == CW'(M - 1));
  end

  // Control and datapath. Each of SQR/MUL/FIN runs the multiplier for M
  // cycles; on the last cycle the result is consumed combinationally and the
  // operands for the next phase are loaded. in_ready is registered so it reads
  // low throughout reset and rises one cycle after release.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      n_r         <= '0;
      sq          <= '0;
      acc         <= '0;
      mul_a       <= '0;
      mul_b       <= '0;
      mul_r       <= '0;
      q_r         <= '0;
      cnt         <= '0;
      stp         <= '0;
      dz_r        <= 1'b0;
      dz_out      <= 1'b0;
      in_ready_r  <= 1'b0;
      out_valid_r <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          in_ready_r <= 1'b1;
          if (bus.in_valid && in_ready_r) begin
            n_r        <= bus.n;
            sq         <= bus.d;
            acc        <= M'(1);
            dz_r       <= (bus.d == '0);
            stp        <= CW'(1);
            mul_a      <= bus.d;
            mul_b      <= bus.d;
            mul_r      <= '0;
            cnt        <= '0;
            in_ready_r <= 1'b0;
            state      <= SQR;
          end
        end

        SQR: begin
          mul_r <= mul_next;
          cnt   <= cnt + CW'(1);
          if (last) begin
            sq    <= mul_next;
            mul_a <= acc;
            mul_b <= mul_next;
            mul_r <= '0;
            cnt   <= '0;
            state <= MUL;
          end
        end

        MUL: begin
          mul_r <= mul_next;
          cnt   <= cnt + CW'(1);
          if (last) begin
            acc   <= mul_next;
            mul_r <= '0;
            cnt   <= '0;
            // After M-1 square/multiply pairs acc holds d^(2^M - 2).
            if (stp == CW'(M - 1)) begin
              mul_a <= mul_next;
              mul_b <= n_r;
              state <= FIN;
            end else begin
              stp   <= stp + CW'(1);
              mul_a <= sq;
              mul_b <= sq;
              state <= SQR;
            end
          end
        end

        FIN: begin
          mul_r <= mul_next;
          cnt   <= cnt + CW'(1);
          if (last) begin
            q_r         <= mul_next;
            dz_out      <= dz_r;
            out_valid_r <= 1'b1;
            mul_r       <= '0;
            cnt         <= '0;
            state       <= DONE;
          end
        end

        DONE: begin
          if (bus.out_ready) begin
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
            state       <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = in_ready_r;
  assign bus.out_valid = out_valid_r;
  assign bus.q         = q_r;
  assign bus.div_zero  = dz_out;

endmodule
